// File: rtl/cpu_ctrl_pkg.sv
// Shared control-stage types: interrupt sequencer states,
// PC-source selects and the sequencer's output bundle.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    SAVE,
    VECTOR,
    ISR,
    RESTORE
  } isr_state_t;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_VEC = 2'b01;
  localparam logic [1:0] PC_RET = 2'b10;

  typedef struct packed {
    logic       save_f;
    logic       return_f;
    logic       stall;
    logic       flush;
    logic [1:0] pc_sel;
    logic       int_ack;
    logic       in_isr;
  } isr_ctl_t;

  function automatic isr_ctl_t ctl_of(isr_state_t s);
    isr_ctl_t c;
    c = '0;
    c.pc_sel = PC_SEQ;
    case (s)
      DRAIN: c.stall = 1'b1;
      SAVE: begin
        c.stall  = 1'b1;
        c.save_f = 1'b1;
      end
      VECTOR: begin
        c.flush   = 1'b1;
        c.pc_sel  = PC_VEC;
        c.int_ack = 1'b1;
      end
      ISR: c.in_isr = 1'b1;
      RESTORE: begin
        c.return_f = 1'b1;
        c.flush    = 1'b1;
        c.pc_sel   = PC_RET;
        c.in_isr   = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/drain_timer.sv
// Loadable 4-bit down-counter timing the pipeline drain
// before the flags are saved.
module drain_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       en,
  input  logic [3:0] load_val,
  output logic       zero
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/ccr_int_ctrl.sv
// Interrupt entry/return sequencer driving the CCR save and
// restore strobes plus the stall/flush/PC-select bracket.
module ccr_int_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       int_req,
  input  logic       rti_dec,
  output logic       saveF,
  output logic       returnF,
  output logic       stall,
  output logic       flush,
  output logic [1:0] pc_sel,
  output logic       int_ack,
  output logic       in_isr,
  output logic       rti_err
);

  localparam logic [3:0] DC    = DRAIN_CYCLES[3:0];
  localparam logic [3:0] DC_M1 = DC - 4'd1;

  isr_state_t state_q;
  isr_state_t state_d;
  isr_ctl_t   ctl_q;
  logic       err_q;
  logic       err_d;
  logic       tmr_ld;
  logic       tmr_en;
  logic       tmr_zero;

  drain_timer u_drain (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_ld),
    .en       (tmr_en),
    .load_val (DC_M1),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d = state_q;
    tmr_ld  = 1'b0;
    tmr_en  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        err_d = rti_dec;
        if (int_req) begin
          if (DC == 4'd0) begin
            state_d = SAVE;
          end else begin
            state_d = DRAIN;
            tmr_ld  = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (tmr_zero) state_d = SAVE;
        else          tmr_en  = 1'b1;
      end
      SAVE:    state_d = VECTOR;
      VECTOR:  state_d = ISR;
      // int_req is masked here; only RTI leaves the handler
      ISR:     if (rti_dec) state_d = RESTORE;
      RESTORE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ctl_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_of(state_d);
      err_q   <= err_d;
    end
  end

  assign saveF   = ctl_q.save_f;
  assign returnF = ctl_q.return_f;
  assign stall   = ctl_q.stall;
  assign flush   = ctl_q.flush;
  assign pc_sel  = ctl_q.pc_sel;
  assign int_ack = ctl_q.int_ack;
  assign in_isr  = ctl_q.in_isr;
  assign rti_err = err_q;

endmodule

// File: tb/tb_ccr_int_ctrl.sv
// Scoreboard bench for ccr_int_ctrl at DRAIN_CYCLES=3 and 0,
// with a small CCR model checking the flag save/restore.
module tb_ccr_int_ctrl;

  localparam logic [8:0] E_IDLE  = 9'b0_0_0_0_00_0_0_0;
  localparam logic [8:0] E_DRAIN = 9'b0_0_1_0_00_0_0_0;
  localparam logic [8:0] E_SAVE  = 9'b1_0_1_0_00_0_0_0;
  localparam logic [8:0] E_VEC   = 9'b0_0_0_1_01_1_0_0;
  localparam logic [8:0] E_ISR   = 9'b0_0_0_0_00_0_1_0;
  localparam logic [8:0] E_REST  = 9'b0_1_0_1_10_0_1_0;
  localparam logic [8:0] E_ERR   = 9'b0_0_0_0_00_0_0_1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req3 = 1'b0, rti3 = 1'b0;
  logic       req0 = 1'b0, rti0 = 1'b0;
  logic       sv3, rt3, st3, fl3, ak3, is3, er3;
  logic       sv0, rt0, st0, fl0, ak0, is0, er0;
  logic [1:0] pc3, pc0;
  logic [8:0] obs3, obs0;

  logic       wr_en = 1'b0;
  logic [3:0] wr_val = 4'd0;
  logic [3:0] ccr_lo, ccr_hi;

  logic [8:0] exp_q[$];
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  ccr_int_ctrl #(.DRAIN_CYCLES(3)) u3 (
    .clk(clk), .rst_n(rst_n), .int_req(req3), .rti_dec(rti3),
    .saveF(sv3), .returnF(rt3), .stall(st3), .flush(fl3),
    .pc_sel(pc3), .int_ack(ak3), .in_isr(is3), .rti_err(er3)
  );

  ccr_int_ctrl #(.DRAIN_CYCLES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .int_req(req0), .rti_dec(rti0),
    .saveF(sv0), .returnF(rt0), .stall(st0), .flush(fl0),
    .pc_sel(pc0), .int_ack(ak0), .in_isr(is0), .rti_err(er0)
  );

  assign obs3 = {sv3, rt3, st3, fl3, pc3, ak3, is3, er3};
  assign obs0 = {sv0, rt0, st0, fl0, pc0, ak0, is0, er0};

  // CCR model: live flags in lo, shadow copy in hi
  always @(posedge clk) begin
    if (sv3)        ccr_hi <= ccr_lo;
    else if (rt3)   ccr_lo <= ccr_hi;
    else if (wr_en) ccr_lo <= wr_val;
  end

  task automatic test_reset();
    logic [8:0] want;
    exp_q.push_back(E_IDLE);
    exp_q.push_back(E_IDLE);
    @(posedge clk); #1;
    want = exp_q.pop_front(); n_vec++;
    if (obs3 !== want) begin
      n_err++; $display("FAIL reset_d3 got %b want %b", obs3, want);
    end
    want = exp_q.pop_front(); n_vec++;
    if (obs0 !== want) begin
      n_err++; $display("FAIL reset_d0 got %b want %b", obs0, want);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_drain();
    logic [8:0] want;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); req3 = (i == 0);
      exp_q.push_back(E_DRAIN);
      @(posedge clk); #1;
      want = exp_q.pop_front(); n_vec++;
      if (obs3 !== want) begin
        n_err++; $display("FAIL mid_drain[%0d] got %b want %b", i, obs3, want);
      end
    end
    @(negedge clk); rst_n = 1'b0;
    exp_q.push_back(E_IDLE);
    #1;
    want = exp_q.pop_front(); n_vec++;
    if (obs3 !== want) begin
      n_err++; $display("FAIL async_rst got %b want %b", obs3, want);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(E_IDLE);
      @(posedge clk); #1;
      want = exp_q.pop_front(); n_vec++;
      if (obs3 !== want) begin
        n_err++; $display("FAIL post_rst[%0d] got %b want %b", i, obs3, want);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_basic();
    bit         rq[8] = '{1, 1, 0, 0, 0, 0, 1, 0};
    logic [8:0] ex[8] = '{E_DRAIN, E_DRAIN, E_DRAIN, E_SAVE,
                          E_VEC, E_ISR, E_ISR, E_ISR};
    logic [8:0] want;
    wr_en = 1'b1; wr_val = 4'b1010;
    @(negedge clk); wr_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); req3 = rq[i]; rti3 = 1'b0;
      exp_q.push_back(ex[i]);
      @(posedge clk); #1;
      want = exp_q.pop_front(); n_vec++;
      if (obs3 !== want) begin
        n_err++; $display("FAIL basic[%0d] got %b want %b", i, obs3, want);
      end
    end
    n_vec++;
    if (ccr_hi !== 4'b1010) begin
      n_err++; $display("FAIL ccr_saved got %b want 1010", ccr_hi);
    end
  endtask

  task automatic test_rti();
    logic [8:0] ex[3] = '{E_ISR, E_REST, E_IDLE};
    logic [8:0] want;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); req3 = 1'b0; rti3 = (i == 1);
      wr_en = (i == 0); wr_val = 4'b0101;
      exp_q.push_back(ex[i]);
      @(posedge clk); #1;
      want = exp_q.pop_front(); n_vec++;
      if (obs3 !== want) begin
        n_err++; $display("FAIL rti[%0d] got %b want %b", i, obs3, want);
      end
      if (i == 0) begin
        n_vec++;
        if (ccr_lo !== 4'b0101) begin
          n_err++; $display("FAIL ccr_live got %b want 0101", ccr_lo);
        end
      end
    end
    wr_en = 1'b0;
    n_vec++;
    if (ccr_lo !== 4'b1010) begin
      n_err++; $display("FAIL ccr_restored got %b want 1010", ccr_lo);
    end
  endtask

  task automatic test_back_to_back();
    bit rq[16] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    bit rt[16] = '{0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    logic [8:0] ex[16] = '{E_DRAIN, E_DRAIN, E_DRAIN, E_SAVE,
                           E_VEC, E_ISR, E_REST, E_IDLE,
                           E_DRAIN, E_DRAIN, E_DRAIN, E_SAVE,
                           E_VEC, E_ISR, E_REST, E_IDLE};
    logic [8:0] want;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); req3 = rq[i]; rti3 = rt[i];
      exp_q.push_back(ex[i]);
      @(posedge clk); #1;
      want = exp_q.pop_front(); n_vec++;
      if (obs3 !== want) begin
        n_err++; $display("FAIL b2b[%0d] got %b want %b", i, obs3, want);
      end
    end
  endtask

  task automatic test_rti_err();
    bit         rt[4] = '{1, 0, 1, 0};
    logic [8:0] ex[4] = '{E_ERR, E_IDLE, E_ERR, E_IDLE};
    logic [8:0] want;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); req3 = 1'b0; rti3 = rt[i];
      exp_q.push_back(ex[i]);
      @(posedge clk); #1;
      want = exp_q.pop_front(); n_vec++;
      if (obs3 !== want) begin
        n_err++; $display("FAIL rti_err[%0d] got %b want %b", i, obs3, want);
      end
    end
  endtask

  task automatic test_drain0();
    bit         rq[5] = '{1, 0, 0, 0, 0};
    bit         rt[5] = '{0, 0, 0, 1, 0};
    logic [8:0] ex[5] = '{E_SAVE, E_VEC, E_ISR, E_REST, E_IDLE};
    logic [8:0] want;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); req0 = rq[i]; rti0 = rt[i];
      exp_q.push_back(ex[i]);
      @(posedge clk); #1;
      want = exp_q.pop_front(); n_vec++;
      if (obs0 !== want) begin
        n_err++; $display("FAIL d0[%0d] got %b want %b", i, obs0, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_drain();
    test_basic();
    test_rti();
    test_back_to_back();
    test_rti_err();
    test_drain0();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL scoreboard_left got %0d want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
